ws2812_frame_receiver: RTL and testbench
========================================

// Module: ws2812_frame_receiver
// PURPOSE
//   Receiving end of the single-wire LED bit stream driven by the snake shift_register.
//   Measures each high pulse, decodes it as 0/1 and assembles the first 24 bits after a
//   reset gap into frame_out, like a real pixel. Later bits are forwarded on dout
//   (daisy-chain). Serves as the on-chip loopback checker and the bench pixel model.
// PARAMETERS
//   W            24   bits per pixel frame (GRB, MSB first)
//   CNT_W        16   width of high/low pulse counters
//   T_BIT_THRESH 30   high cycles >= this decode as 1, else 0 (0.6 us @ 50 MHz)
//   T_MAX_HIGH   60   high cycles > this is a protocol error
//   T_RESET      250  low cycles >= this form a reset/latch gap (5 us @ 50 MHz)
// PORTS
//   clk          in   1      system clock
//   rst          in   1      synchronous reset, active-high
//   din          in   1      serial LED data line, asynchronous
//   dout         out  1      forwarded data line to next pixel
//   frame_out    out  W      last complete frame, held until next frame_valid
//   frame_valid  out  1      1-cycle pulse, frame_out updated this cycle
//   latch        out  1      1-cycle pulse on detection of a reset gap
//   err          out  1      1-cycle pulse on protocol error
//   err_code     out  2      01 high too long, 10 short frame; held until next err
// BEHAVIOUR
//   - Reset (rst=1 at clk edge): all outputs 0, counters 0, state S_SYNC. rst dominates
//     any simultaneous event. A partial frame is discarded without err.
//   - din passes through a 2-flop synchronizer (din_s). All timing uses din_s.
//     The 2-cycle latency is identical on every edge, so pulse widths are unaffected.
//   - hi_cnt counts cycles with din_s=1. lo_cnt counts cycles with din_s=0.
//     Both clear on the opposite level and saturate at 2^CNT_W-1 (no wrap).
//   - FSM:
//     S_SYNC: ignore bits. When lo_cnt reaches T_RESET, pulse latch and go S_LOW.
//       Power-up or mid-stream entry never decodes a partial stream.
//     S_LOW: wait for a din_s rising edge, then go S_HIGH. If lo_cnt reaches T_RESET,
//       pulse latch; additionally, if 0 < bit_cnt < W, pulse err with err_code=10.
//       Then bit_cnt=0 and fwd_en=0.
//     S_HIGH: on a din_s falling edge, decode bit = (hi_cnt >= T_BIT_THRESH) and go S_LOW.
//       If hi_cnt exceeds T_MAX_HIGH while high: pulse err, err_code=01, discard the
//       partial frame, bit_cnt=0, fwd_en=0, go S_SYNC.
//   - Decoded bit, bit_cnt < W: shift into shreg MSB first, bit_cnt++.
//     On the W-th bit, in the same cycle as the falling edge decode:
//       frame_out <= full shreg incl. this bit; frame_valid=1; fwd_en=1.
//   - dout = din_s & fwd_en, registered: 1 cycle after din_s, 3 cycles after din.
//     fwd_en rises after the W-th falling edge, so the first bit is never forwarded.
//     fwd_en clears on latch, so the reset gap reaches dout as low.
//   - latch and frame_valid never pulse in the same cycle.
//     err and latch may pulse together (short frame).
// TESTING
//   1. rst, din low 300 cyc, send 0xFF0000 (hi 40/lo 20 = 1, hi 15/lo 45 = 0)
//      -> latch at lo_cnt=250; frame_valid once; frame_out=0xFF0000; dout stays 0.
//   2. Gap, frames 0x123456 then 0xABCDEF back-to-back
//      -> frame_out=0x123456, one frame_valid; 24 pulses of 2nd frame on dout, widths
//      equal, 3 cyc after din; after gap dout=0, latch=1.
//   3. Gap, 10 bits, then 300 cyc low
//      -> latch and err same cycle, err_code=10; no frame_valid; next full frame decodes.
//   4. Gap, 5 bits, hold din high 100 cyc
//      -> err at hi_cnt=61, err_code=01; bits ignored until a 250-cyc gap.
//   5. No gap after rst, start mid-frame
//      -> no frame_valid before first latch; first frame after gap exact.
//   6. Assert rst after bit 12, release, gap + 0x00FF00
//      -> outputs 0 during rst, no err; frame_out=0x00FF00.
//   7. Boundaries: hi 29 vs 30 -> bit 0 vs 1; hi 60 ok, 61 err; low 249 no latch, 250 latch.

Source files
------------

// File: rtl/ws2812_frame_receiver.sv
// WS2812-style pixel receiver: decodes pulse widths into a W-bit frame
// and forwards every later bit on dout, like a daisy-chained LED.
module ws2812_frame_receiver #(
    parameter int W            = 24,
    parameter int CNT_W        = 16,
    parameter int T_BIT_THRESH = 30,
    parameter int T_MAX_HIGH   = 60,
    parameter int T_RESET      = 250
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         din,
    output logic         dout,
    output logic [W-1:0] frame_out,
    output logic         frame_valid,
    output logic         latch,
    output logic         err,
    output logic [1:0]   err_code
);
    localparam int BW = $clog2(W + 1);
    localparam logic [CNT_W-1:0] TH_C  = CNT_W'(T_BIT_THRESH);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(T_MAX_HIGH);
    localparam logic [CNT_W-1:0] RST_C = CNT_W'(T_RESET);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
    localparam logic [BW-1:0]    W_C   = BW'(W);
    localparam logic [BW-1:0]    WL_C  = BW'(W - 1);

    typedef enum logic [1:0] {S_SYNC, S_LOW, S_HIGH} state_t;

    state_t           state_q;
    logic             din_meta_q, din_s_q;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0] lo_cnt_q, lo_cnt_d;
    logic [BW-1:0]    bit_cnt_q;
    logic [W-1:0]     shreg_q, shreg_d;
    logic [W-1:0]     frame_q;
    logic             fwd_en_q, dout_q, fv_q, latch_q, err_q;
    logic [1:0]       code_q;
    logic             bit_val, gap;

    always_comb begin
        hi_cnt_d = '0;
        lo_cnt_d = '0;
        if (din_s_q)
            hi_cnt_d = (hi_cnt_q == '1) ? hi_cnt_q : hi_cnt_q + ONE_C;
        else
            lo_cnt_d = (lo_cnt_q == '1) ? lo_cnt_q : lo_cnt_q + ONE_C;
        // hi_cnt_q still holds the full pulse width in the falling-edge cycle
        bit_val = (hi_cnt_q >= TH_C);
        shreg_d = {shreg_q[W-2:0], bit_val};
        gap     = (lo_cnt_d == RST_C);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_SYNC;
            din_meta_q <= 1'b0;
            din_s_q    <= 1'b0;
            hi_cnt_q   <= '0;
            lo_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            frame_q    <= '0;
            fwd_en_q   <= 1'b0;
            dout_q     <= 1'b0;
            fv_q       <= 1'b0;
            latch_q    <= 1'b0;
            err_q      <= 1'b0;
            code_q     <= 2'b00;
        end else begin
            din_meta_q <= din;
            din_s_q    <= din_meta_q;
            hi_cnt_q   <= hi_cnt_d;
            lo_cnt_q   <= lo_cnt_d;
            dout_q     <= din_s_q & fwd_en_q;
            fv_q       <= 1'b0;
            latch_q    <= 1'b0;
            err_q      <= 1'b0;
            unique case (state_q)
                S_SYNC: begin
                    if (gap) begin
                        latch_q   <= 1'b1;
                        bit_cnt_q <= '0;
                        fwd_en_q  <= 1'b0;
                        state_q   <= S_LOW;
                    end
                end
                S_LOW: begin
                    if (din_s_q) begin
                        state_q <= S_HIGH;
                    end else if (gap) begin
                        latch_q <= 1'b1;
                        if (bit_cnt_q != '0 && bit_cnt_q < W_C) begin
                            err_q  <= 1'b1;
                            code_q <= 2'b10;
                        end
                        bit_cnt_q <= '0;
                        fwd_en_q  <= 1'b0;
                    end
                end
                S_HIGH: begin
                    if (din_s_q) begin
                        if (hi_cnt_d > MAX_C) begin
                            err_q     <= 1'b1;
                            code_q    <= 2'b01;
                            bit_cnt_q <= '0;
                            fwd_en_q  <= 1'b0;
                            state_q   <= S_SYNC;
                        end
                    end else begin
                        state_q <= S_LOW;
                        if (bit_cnt_q < W_C) begin
                            shreg_q   <= shreg_d;
                            bit_cnt_q <= bit_cnt_q + BW'(1);
                            if (bit_cnt_q == WL_C) begin
                                frame_q  <= shreg_d;
                                fv_q     <= 1'b1;
                                fwd_en_q <= 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= S_SYNC;
            endcase
        end
    end

    assign dout        = dout_q;
    assign frame_out   = frame_q;
    assign frame_valid = fv_q;
    assign latch       = latch_q;
    assign err         = err_q;
    assign err_code    = code_q;
endmodule

// File: tb/tb_ws2812_frame_receiver.sv
// Directed bench for ws2812_frame_receiver: pulse-width stimulus,
// event counters sampled on the falling clock edge.
module tb_ws2812_frame_receiver;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din = 1'b0;
    logic        dout;
    logic [23:0] frame_out;
    logic        frame_valid, latch, err;
    logic [1:0]  err_code;

    ws2812_frame_receiver dut (
        .clk(clk), .rst(rst), .din(din), .dout(dout),
        .frame_out(frame_out), .frame_valid(frame_valid),
        .latch(latch), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, n_fv = 0, n_lat = 0, n_err = 0, n_both = 0, n_lf = 0;
    int n_dhi = 0, n_dp = 0, n_dbad = 0, n_rbad = 0;
    int lat_cyc = 0, err_cyc = 0;
    logic [1:0] last_code = 2'b00;
    logic [2:0] din_h = 3'b000;
    logic dout_prev = 1'b0, rst_prev = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (frame_valid) n_fv = n_fv + 1;
        if (latch) begin n_lat = n_lat + 1; lat_cyc = cyc; end
        if (err) begin
            n_err = n_err + 1; err_cyc = cyc; last_code = err_code;
        end
        if (latch && err) n_both = n_both + 1;
        if (latch && frame_valid) n_lf = n_lf + 1;
        if (dout) n_dhi = n_dhi + 1;
        if (dout && !dout_prev) n_dp = n_dp + 1;
        if (dout && !din_h[2]) n_dbad = n_dbad + 1;
        if (rst && rst_prev && (dout || frame_valid || latch || err ||
            err_code != 2'b00 || frame_out != 24'h0)) n_rbad = n_rbad + 1;
        din_h = {din_h[1:0], din};
        dout_prev = dout;
        rst_prev = rst;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int s_fv, s_lat, s_err, s_both, s_dhi, s_dp, c0;
    task automatic snap();
        s_fv = n_fv; s_lat = n_lat; s_err = n_err; s_both = n_both;
        s_dhi = n_dhi; s_dp = n_dp;
    endtask

    task automatic drive(input logic lvl, input int n);
        din = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic pulse(input int hi, input int lo);
        drive(1'b1, hi);
        drive(1'b0, lo);
    endtask
    task automatic send_bits(input logic [23:0] v, input int n);
        for (int i = n - 1; i >= 0; i--)
            if (v[i]) pulse(40, 20); else pulse(15, 45);
    endtask
    task automatic do_rst(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        do_rst(5);
        chk("rst_frame", 32'(frame_out), 32'h0);
        chk("rst_outs", {28'h0, dout, frame_valid, latch, err}, 32'h0);
        chk("rst_code", 32'(err_code), 32'h0);

        // 1: single frame after power-up gap
        snap();
        drive(1'b0, 300);
        send_bits(24'hFF0000, 24);
        drive(1'b0, 10);
        chk("t1_latch", n_lat - s_lat, 1);
        chk("t1_fv", n_fv - s_fv, 1);
        chk("t1_frame", 32'(frame_out), 32'hFF0000);
        chk("t1_dout", n_dhi - s_dhi, 0);
        chk("t1_err", n_err - s_err, 0);

        // 2: back-to-back frames, second forwarded
        drive(1'b0, 300);
        snap();
        send_bits(24'h123456, 24);
        send_bits(24'hABCDEF, 24);
        drive(1'b0, 300);
        chk("t2_fv", n_fv - s_fv, 1);
        chk("t2_frame", 32'(frame_out), 32'h123456);
        chk("t2_dpulses", n_dp - s_dp, 24);
        chk("t2_dhigh", n_dhi - s_dhi, 785);
        chk("t2_latch", n_lat - s_lat, 1);
        chk("t2_err", n_err - s_err, 0);
        chk("t2_dout_end", 32'(dout), 0);

        // 3: short frame
        drive(1'b0, 300);
        snap();
        send_bits(24'h3A5, 10);
        drive(1'b0, 300);
        chk("t3_latch", n_lat - s_lat, 1);
        chk("t3_err", n_err - s_err, 1);
        chk("t3_same", n_both - s_both, 1);
        chk("t3_code", 32'(last_code), 2);
        chk("t3_fv", n_fv - s_fv, 0);
        snap();
        send_bits(24'hC0FFEE, 24);
        drive(1'b0, 100);
        chk("t3_fv2", n_fv - s_fv, 1);
        chk("t3_frame2", 32'(frame_out), 32'hC0FFEE);

        // 4: high too long, then ignore until gap
        drive(1'b0, 300);
        send_bits(24'h15, 5);
        snap();
        c0 = cyc;
        drive(1'b1, 100);
        chk("t4_err", n_err - s_err, 1);
        chk("t4_err_at61", err_cyc - c0, 64);
        chk("t4_code", 32'(last_code), 1);
        drive(1'b0, 60);
        send_bits(24'hAAAAAA, 24);
        chk("t4_ignored", n_fv - s_fv, 0);
        drive(1'b0, 300);
        chk("t4_latch", n_lat - s_lat, 1);
        chk("t4_err_once", n_err - s_err, 1);

        // 5: start mid-stream after reset
        do_rst(3);
        snap();
        send_bits(24'h55555, 20);
        chk("t5_no_fv", n_fv - s_fv, 0);
        chk("t5_no_latch", n_lat - s_lat, 0);
        drive(1'b0, 300);
        send_bits(24'h5A5A5A, 24);
        drive(1'b0, 100);
        chk("t5_fv", n_fv - s_fv, 1);
        chk("t5_frame", 32'(frame_out), 32'h5A5A5A);

        // 6: reset in mid-frame
        drive(1'b0, 300);
        snap();
        send_bits(24'hFFF, 12);
        do_rst(5);
        chk("t6_rst_frame", 32'(frame_out), 0);
        chk("t6_no_err", n_err - s_err, 0);
        drive(1'b0, 300);
        send_bits(24'h00FF00, 24);
        drive(1'b0, 100);
        chk("t6_frame", 32'(frame_out), 32'h00FF00);
        chk("t6_fv", n_fv - s_fv, 1);
        chk("t6_err", n_err - s_err, 0);

        // 7: boundaries
        drive(1'b0, 300);
        snap();
        drive(1'b1, 40);
        drive(1'b0, 249);
        drive(1'b1, 40);
        c0 = cyc;
        drive(1'b0, 250);
        drive(1'b0, 5);
        chk("t7_lo249_250", n_lat - s_lat, 1);
        chk("t7_latch_at250", lat_cyc - c0, 253);
        chk("t7_short_code", 32'(last_code), 2);
        snap();
        pulse(60, 300);
        chk("t7_hi60_err", n_err - s_err, 1);
        chk("t7_hi60_code", 32'(last_code), 2);
        snap();
        pulse(61, 300);
        chk("t7_hi61_err", n_err - s_err, 1);
        chk("t7_hi61_code", 32'(last_code), 1);
        snap();
        for (int i = 0; i < 12; i++) pulse(30, 30);
        for (int i = 0; i < 12; i++) pulse(29, 31);
        drive(1'b0, 100);
        chk("t7_thresh_fv", n_fv - s_fv, 1);
        chk("t7_thresh_frame", 32'(frame_out), 32'hFFF000);

        chk("rst_outputs_zero", n_rbad, 0);
        chk("latch_fv_overlap", n_lf, 0);
        chk("dout_delay", n_dbad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
